// File: rtl/upower_alu_seq_pkg.sv
// Shared types for the sequential uPower ALU: op codes, FSM states, CR0 bit positions.
package upower_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUBF  = 4'd1,
    OP_AND   = 4'd2,
    OP_NAND  = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_EXTSW = 4'd6,
    OP_CMP   = 4'd7,
    OP_BEQ   = 4'd8,
    OP_BNE   = 4'd9,
    OP_MULLD = 4'd10,
    OP_DIVD  = 4'd11,
    OP_DIVDU = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  localparam int unsigned CR0_LT = 2;
  localparam int unsigned CR0_GT = 1;
  localparam int unsigned CR0_EQ = 0;

endpackage

// File: rtl/upower_alu_seq_if.sv
// Request/response bundle between operand read and the ALU; flush rides along with the request side.
interface upower_alu_seq_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [2:0]      cr0;
  logic            branch;
  logic            ov;
  logic            ill;

  modport master (
    output flush, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, cr0, branch, ov, ill
  );

  modport slave (
    input  flush, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, cr0, branch, ov, ill
  );
endinterface

// File: rtl/upower_alu_seq_muldiv.sv
// Iterative datapath: shift-add multiplier and restoring divider on magnitudes, one step per cycle.
module upower_muldiv_iter
  import upower_alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            abort,
  input  logic            start,
  input  alu_op_e         mode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);
  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q, opa_q, opb_q;
  logic [XLEN-1:0] acc_n, opa_n, opb_n;
  logic            mul_q, neg_q;
  logic [XLEN:0]   rem_sh;
  logic            take;
  logic            is_mul, is_divd;
  logic [XLEN-1:0] mag_a, mag_b;

  // Operand preparation at start: DIVD works on magnitudes, MULLD low bits are sign-agnostic.
  always_comb begin
    is_mul  = (mode == OP_MULLD);
    is_divd = (mode == OP_DIVD);
    mag_a   = (is_divd && a[XLEN-1]) ? -a : a;
    mag_b   = (is_divd && b[XLEN-1]) ? -b : b;
  end

  // One multiply or divide step; acc holds product or partial remainder, opa the shifting operand.
  // done is raised during the last step so the caller registers res on that same edge.
  always_comb begin
    rem_sh = {acc_q, opa_q[XLEN-1]};
    take   = (rem_sh >= {1'b0, opb_q});
    if (mul_q) begin
      acc_n = acc_q + (opb_q[0] ? opa_q : '0);
      opa_n = opa_q << 1;
      opb_n = opb_q >> 1;
    end else begin
      acc_n = take ? (rem_sh[XLEN-1:0] - opb_q) : rem_sh[XLEN-1:0];
      opa_n = {opa_q[XLEN-2:0], take};
      opb_n = opb_q;
    end
    done = (cnt_q == CW'(1));
    res  = mul_q ? acc_n : (neg_q ? -opa_n : opa_n);
  end

  // Iteration registers: load on start, step while the counter is non-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      mul_q <= 1'b0;
      neg_q <= 1'b0;
    end else if (abort) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= CW'(XLEN);
      acc_q <= '0;
      opa_q <= is_mul ? a : mag_a;
      opb_q <= is_mul ? b : mag_b;
      mul_q <= is_mul;
      neg_q <= is_divd && (a[XLEN-1] ^ b[XLEN-1]);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      acc_q <= acc_n;
      opa_q <= opa_n;
      opb_q <= opb_n;
    end
  end

endmodule

// File: rtl/upower_alu_seq.sv
// Sequential uPower ALU: handshake FSM, single-cycle ops, flags, and the iterative mul/div unit.
module upower_alu_seq
  import upower_alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input logic             clk,
  input logic             rst_n,
  upower_alu_seq_if.slave bus
);
  alu_state_e      state_q, state_d;
  alu_op_e         op;
  logic            in_ready, accept, start, load_sc, load_md;
  logic            div_zero, divd_ovf, iter_op;
  logic [XLEN-1:0] sc_result;
  logic [2:0]      sc_cr0;
  logic            sc_branch, sc_ov, sc_ill, sc_cmp;
  logic            md_done;
  logic [XLEN-1:0] md_res;
  logic [XLEN-1:0] result_q;
  logic [2:0]      cr0_q;
  logic            branch_q, ov_q, ill_q;

  function automatic logic [2:0] cr0_of(input logic [XLEN-1:0] v);
    logic [2:0] f;
    f = '0;
    if (v[XLEN-1])   f[CR0_LT] = 1'b1;
    else if (v == '0) f[CR0_EQ] = 1'b1;
    else             f[CR0_GT] = 1'b1;
    return f;
  endfunction

  assign op       = alu_op_e'(bus.op);
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready && !bus.flush;
  assign div_zero = (bus.b == '0);
  assign divd_ovf = (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
  assign iter_op  = (op == OP_MULLD) || ((op == OP_DIVDU) && !div_zero) ||
                    ((op == OP_DIVD) && !div_zero && !divd_ovf);

  // Single-cycle results, degenerate divides and illegal-op detection.
  always_comb begin
    sc_result = '0;
    sc_branch = 1'b0;
    sc_ov     = 1'b0;
    sc_ill    = 1'b0;
    sc_cmp    = 1'b0;
    case (op)
      OP_ADD:   sc_result = bus.a + bus.b;
      OP_SUBF:  sc_result = bus.b - bus.a;
      OP_AND:   sc_result = bus.a & bus.b;
      OP_NAND:  sc_result = ~(bus.a & bus.b);
      OP_OR:    sc_result = bus.a | bus.b;
      OP_XOR:   sc_result = bus.a ^ bus.b;
      OP_EXTSW: sc_result = {{(XLEN/2){bus.a[XLEN/2-1]}}, bus.a[XLEN/2-1:0]};
      OP_CMP:   sc_cmp = 1'b1;
      OP_BEQ: begin
        sc_result = bus.a - bus.b;
        sc_branch = (bus.a == bus.b);
      end
      OP_BNE: begin
        sc_result = bus.a - bus.b;
        sc_branch = (bus.a != bus.b);
      end
      OP_MULLD: ;
      OP_DIVD:  sc_ov = div_zero || divd_ovf;
      OP_DIVDU: sc_ov = div_zero;
      default:  sc_ill = 1'b1;
    endcase
    if (sc_cmp) begin
      sc_cr0 = '0;
      if ($signed(bus.a) < $signed(bus.b))      sc_cr0[CR0_LT] = 1'b1;
      else if ($signed(bus.a) > $signed(bus.b)) sc_cr0[CR0_GT] = 1'b1;
      else                                      sc_cr0[CR0_EQ] = 1'b1;
    end else begin
      sc_cr0 = cr0_of(sc_result);
    end
  end

  // Next state and load strobes; flush overrides everything.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    load_sc = 1'b0;
    load_md = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (iter_op) begin
            state_d = BUSY;
            start   = 1'b1;
          end else begin
            state_d = DONE;
            load_sc = 1'b1;
          end
        end else if (state_q == DONE && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (md_done) begin
          state_d = DONE;
          load_md = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d = IDLE;
      start   = 1'b0;
      load_sc = 1'b0;
      load_md = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Output registers, held while the result waits for out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      cr0_q    <= '0;
      branch_q <= 1'b0;
      ov_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else if (load_sc) begin
      result_q <= sc_result;
      cr0_q    <= sc_cr0;
      branch_q <= sc_branch;
      ov_q     <= sc_ov;
      ill_q    <= sc_ill;
    end else if (load_md) begin
      result_q <= md_res;
      cr0_q    <= cr0_of(md_res);
      branch_q <= 1'b0;
      ov_q     <= 1'b0;
      ill_q    <= 1'b0;
    end
  end

  upower_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .abort (bus.flush),
    .start (start),
    .mode  (op),
    .a     (bus.a),
    .b     (bus.b),
    .done  (md_done),
    .res   (md_res)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.cr0       = cr0_q;
  assign bus.branch    = branch_q;
  assign bus.ov        = ov_q;
  assign bus.ill       = ill_q;

endmodule

// File: tb/tb_upower_alu_seq.sv
// Directed bench for upower_alu_seq at XLEN=64: vector table plus handshake/abort sequences.
module tb_upower_alu_seq;
  import upower_alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  upower_alu_seq_if #(.XLEN(64)) bus ();

  upower_alu_seq #(.XLEN(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [2:0]  cr0;
    logic        br;
    logic        ov;
    logic        ill;
    int unsigned lat;
  } vec_t;

  vec_t vecs[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void add(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] res, input logic [2:0] cr0, input logic br,
                              input logic ov, input logic ill, input int unsigned lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.cr0 = cr0;
    v.br = br; v.ov = ov; v.ill = ill; v.lat = lat;
    vecs.push_back(v);
  endfunction

  // Offer one op with out_ready low, scramble operands after accept, wait (bounded) for out_valid.
  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        output int unsigned lat, output int unsigned busy_rdy);
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    chk("accept_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = {$urandom(), $urandom()};
    bus.b = {$urandom(), $urandom()};
    lat = 0; busy_rdy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.out_valid && bus.in_ready) busy_rdy++;
    end while (!bus.out_valid && lat < 200);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat, busy_rdy, seen;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = '0;
    bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;

    add(OP_ADD,   64'd8, 64'd7, 64'd15, 3'b010, 0, 0, 0, 1);
    add(OP_SUBF,  64'd8, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 0, 0, 0, 1);
    add(OP_AND,   64'hF0F0, 64'hFF00, 64'hF000, 3'b010, 0, 0, 0, 1);
    add(OP_NAND,  64'hF0F0, 64'hFF00, 64'hFFFF_FFFF_FFFF_0FFF, 3'b100, 0, 0, 0, 1);
    add(OP_OR,    64'hF0F0, 64'h0F0F, 64'hFFFF, 3'b010, 0, 0, 0, 1);
    add(OP_XOR,   64'd5, 64'd5, 64'd0, 3'b001, 0, 0, 0, 1);
    add(OP_EXTSW, 64'h1234_5678_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 3'b100, 0, 0, 0, 1);
    add(OP_EXTSW, 64'hFFFF_0000_7000_0000, 64'd0, 64'h0000_0000_7000_0000, 3'b010, 0, 0, 0, 1);
    add(OP_CMP,   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 3'b100, 0, 0, 0, 1);
    add(OP_CMP,   64'd3, 64'd3, 64'd0, 3'b001, 0, 0, 0, 1);
    add(OP_CMP,   64'd9, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 3'b010, 0, 0, 0, 1);
    add(OP_BEQ,   64'd5, 64'd5, 64'd0, 3'b001, 1, 0, 0, 1);
    add(OP_BNE,   64'd5, 64'd5, 64'd0, 3'b001, 0, 0, 0, 1);
    add(OP_BNE,   64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 3'b100, 1, 0, 0, 1);
    add(OP_ADD,   64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 3'b100, 0, 0, 0, 1);
    add(OP_MULLD, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 3'b100, 0, 0, 0, 65);
    add(OP_MULLD, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 3'b001, 0, 0, 0, 65);
    add(OP_DIVD,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 3'b100, 0, 0, 0, 65);
    add(OP_DIVD,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 3'b100, 0, 0, 0, 65);
    add(OP_DIVD,  64'h8000_0000_0000_0000, 64'd2, 64'hC000_0000_0000_0000, 3'b100, 0, 0, 0, 65);
    add(OP_DIVDU, 64'd100, 64'd7, 64'd14, 3'b010, 0, 0, 0, 65);
    add(OP_DIVDU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF, 64'h1_0000_0001, 3'b010, 0, 0, 0, 65);
    add(OP_DIVD,  64'd7, 64'd0, 64'd0, 3'b001, 0, 1, 0, 1);
    add(OP_DIVD,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 3'b001, 0, 1, 0, 1);
    add(OP_DIVDU, 64'd5, 64'd0, 64'd0, 3'b001, 0, 1, 0, 1);
    add(4'd14,    64'd1, 64'd2, 64'd0, 3'b001, 0, 0, 1, 1);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_cr0", 64'(bus.cr0), 64'd0);
    chk("rst_flags", {61'd0, bus.branch, bus.ov, bus.ill}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_rdy);
      chk($sformatf("v%0d.out_valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("v%0d.latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d.result", i), bus.result, vecs[i].res);
      chk($sformatf("v%0d.cr0", i), 64'(bus.cr0), 64'(vecs[i].cr0));
      chk($sformatf("v%0d.branch", i), 64'(bus.branch), 64'(vecs[i].br));
      chk($sformatf("v%0d.ov", i), 64'(bus.ov), 64'(vecs[i].ov));
      chk($sformatf("v%0d.ill", i), 64'(bus.ill), 64'(vecs[i].ill));
      if (vecs[i].lat > 1) chk($sformatf("v%0d.busy_in_ready", i), 64'(busy_rdy), 64'd0);
      consume();
    end

    // Backpressure: result held stable, no new accept.
    run_op(OP_ADD, 64'd10, 64'd20, lat, busy_rdy);
    chk("bp_latency", 64'(lat), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d.out_valid", k), 64'(bus.out_valid), 64'd1);
      chk($sformatf("bp%0d.result", k), bus.result, 64'd30);
      chk($sformatf("bp%0d.cr0", k), 64'(bus.cr0), 64'b010);
      chk($sformatf("bp%0d.in_ready", k), 64'(bus.in_ready), 64'd0);
    end
    consume();

    // Back-to-back single-cycle ops with out_ready held high.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.op = OP_ADD;
    for (int i = 1; i <= 10; i++) begin
      bus.a = 64'(i); bus.b = 64'd100;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b%0d.out_valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("b2b%0d.result", i), bus.result, 64'(i + 100));
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Flush at cycle 20 of a DIVD.
    @(negedge clk);
    bus.op = OP_DIVD; bus.a = 64'd1000; bus.b = 64'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (20) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_idle_in_ready", 64'(bus.in_ready), 64'd1);
    seen = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("flush_never_valid", 64'(seen), 64'd0);

    // Flush concurrent with an offer: offer is dropped.
    bus.op = OP_ADD; bus.a = 64'd1; bus.b = 64'd1;
    bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_drop_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_drop_result", bus.result, 64'd110);

    // Asynchronous reset at cycle 30 of a MULLD.
    bus.op = OP_MULLD; bus.a = 64'd123; bus.b = 64'd456; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_rst_in_ready", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_result", bus.result, 64'd0);
    chk("mid_rst_cr0", 64'(bus.cr0), 64'd0);
    chk("mid_rst_flags", {61'd0, bus.branch, bus.ov, bus.ill}, 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_ADD, 64'd2, 64'd3, lat, busy_rdy);
    chk("post_rst_latency", 64'(lat), 64'd1);
    chk("post_rst_result", bus.result, 64'd5);
    chk("post_rst_cr0", 64'(bus.cr0), 64'b010);
    consume();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/upower_alu_seq.md
# upower_alu_seq

Parametrised, sequential successor to the combinational uPower ALU. Accepts one decoded ALU operation per valid/ready transaction and returns a registered result, condition flags and branch decision. Single-cycle ops complete with one-cycle latency; MULLD/DIVD/DIVDU run on an iterative shift/add-subtract datapath. The block sits between decode/operand read and writeback in the uPower execute stage.

## Interface
- `XLEN`: default 64. Datapath width; legal values are even numbers from 16 to 64.
- `clk`, input, 1: Sole clock, rising edge.
- `rst_n`, input, 1: Asynchronous assert, active-low reset.
- `flush`, input, 1: Synchronous abort of any in-flight or held op.
- `in_valid`, input, 1: Operation offered.
- `in_ready`, output, 1: Block can accept.
- `op`, input, 4: `alu_op_e` operation code.
- `a`, input, XLEN: Operand A (RS/RA).
- `b`, input, XLEN: Operand B (RT/RB or extended immediate).
- `out_valid`, output, 1: Result valid; held until accepted.
- `out_ready`, input, 1: Consumer accepts the result.
- `result`, output, XLEN: Result value.
- `cr0`, output, 3: {LT, GT, EQ}.
- `branch`, output, 1: Branch taken (BEQ/BNE only; 0 otherwise).
- `ov`, output, 1: Divide by zero or signed divide overflow.
- `ill`, output, 1: Unknown `op`.

## Operation
- Op encodings:
  - ADD=0: a+b.
  - SUBF=1: b−a.
  - AND=2, NAND=3, OR=4, XOR=5: bitwise.
  - EXTSW=6: sign-extend a[XLEN/2−1:0].
  - CMP=7: result 0; flags from signed a vs b.
  - BEQ=8, BNE=9: result a−b; branch = (a==b) or (a!=b) respectively.
  - MULLD=10: low XLEN bits of the product.
  - DIVD=11: signed quotient, truncated toward zero.
  - DIVDU=12: unsigned quotient.
  - 13–15 are illegal.
- Arithmetic wraps modulo 2^XLEN. No carry-out is produced.
- `cr0`: for every op except CMP, set from `result` compared as signed against 0. Exactly one bit is set.
- DIVD/DIVDU with b==0: result 0, ov=1, one-cycle latency (no iteration). DIVD with a=most-negative and b=−1: same behaviour.
- Illegal op: result 0, cr0=3'b001, ill=1, one-cycle latency.
- FSM:
  - IDLE: in_ready=1. On an accepted single-cycle op → DONE. On an accepted MULLD/DIV (non-degenerate) → BUSY, iteration counter = XLEN.
  - BUSY: in_ready=0. One mul/div step per cycle. Counter reaches 0 → DONE.
  - DONE: out_valid=1, outputs stable. If out_ready=1 and no new accept → IDLE. If out_ready=1 and in_valid=1 → accept the new op, go directly to DONE or BUSY.
- in_ready = (state==IDLE) or (state==DONE and out_ready). There is no combinational path from in_valid to out_valid.
- flush: next state IDLE and out_valid=0 regardless of state. Any concurrent in_valid is ignored that cycle.
- Reset values: state IDLE; out_valid, result, cr0, branch, ov, ill all 0. Internal counter and registers also 0. Reset mid-BUSY discards the op immediately (asynchronous).

## Timing
- Accept occurs at edge E (in_valid & in_ready).
- Single-cycle, degenerate-divide and illegal ops: out_valid=1 after edge E+1.
- MULLD/DIVD/DIVDU: out_valid=1 after edge E+XLEN+1; in_ready=0 from E+1 through E+XLEN.
- Throughput: one single-cycle op per clock when out_ready is held high.
- Outputs are stable while out_valid & !out_ready. Operands are captured at accept; a/b may change afterwards.

## Structure
- Package `upower_alu_pkg`: `alu_op_e` enum (4-bit, encodings above), `alu_state_e` {IDLE, BUSY, DONE}, CR0 bit index constants.
- Sub-module `upower_muldiv_iter` (XLEN parameter): start/mode inputs, shift-add multiplier and restoring unsigned divider on operand magnitudes, sign fix-up for DIVD, and a done pulse. The top level holds the FSM, the single-cycle ops, flags and the handshake.

## Test plan
- XLEN=64, ADD a=8 b=7 → result 15, cr0=3'b010, out_valid exactly 1 cycle after accept; then SUBF a=8 b=7 → 0xFFFF_FFFF_FFFF_FFFF, cr0=3'b100.
- MULLD a=−3 b=5 → −15, cr0=3'b100; out_valid exactly 65 cycles after accept; in_ready=0 for cycles 1–64.
- DIVD a=−7 b=2 → −3. DIVDU a=100 b=7 → 14. DIVD b=0 → result 0, ov=1, latency 1. DIVD a=0x8000_0000_0000_0000 b=−1 → result 0, ov=1.
- BEQ a=5 b=5 → branch=1, result 0, cr0=3'b001. BNE a=5 b=5 → branch=0. Op 14 → ill=1, result 0.
- Backpressure: out_ready low for 5 cycles after an ADD → result/flags stable, in_ready=0. Then 10 back-to-back ADDs with out_ready=1 → 10 results on consecutive cycles, in order.
- Mid-op abort: flush at cycle 20 of a DIVD → out_valid never rises and state is IDLE next cycle. rst_n pulse at cycle 30 of a MULLD → all outputs 0 immediately. A following ADD 2+3 → 5.
